// File: rtl/joybus_poll_sched.sv
// JOYBUS poll scheduler: probes for a controller (0x00), then polls
// buttons (0x01) at a fixed interval and tracks controller presence.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   enable              run the probe/poll sequence
//   phy_tx_start/cmd    command launch pulse and command byte
//   phy_tx_done         command fully sent
//   phy_rx_en           response awaited
//   phy_rx_done/data/   response complete, left-justified bits,
//   phy_rx_bytes        and received byte count
//   btn_state           last good poll response ([31]=A [30]=B [29]=Z)
//   state_valid         pulse when btn_state updates
//   cntlr_id            device ID from last good probe
//   cntlr_present       controller detected and responding
//   err_timeout         pulse on a counted failed transaction
//
// Build option: JB_SCHED_RETRY_EN re-issues a failed poll once.

module joybus_poll_sched #(
  parameter int unsigned POLL_CYCLES    = 416_666,
  parameter int unsigned TIMEOUT_CYCLES = 2_500,
  parameter int unsigned MAX_MISSES     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        phy_tx_start,
  output logic [7:0]  phy_tx_cmd,
  input  logic        phy_tx_done,
  output logic        phy_rx_en,
  input  logic        phy_rx_done,
  input  logic [31:0] phy_rx_data,
  input  logic [2:0]  phy_rx_bytes,
  output logic [31:0] btn_state,
  output logic        state_valid,
  output logic [15:0] cntlr_id,
  output logic        cntlr_present,
  output logic        err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int MW = $clog2(MAX_MISSES + 1);

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] P_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [PW-1:0] P_MAX  = PW'(POLL_CYCLES);
  localparam logic [MW-1:0] M_LAST = MW'(MAX_MISSES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TX   = 2'd1;
  localparam logic [1:0] S_RX   = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam logic [7:0] CMD_PROBE = 8'h00;
  localparam logic [7:0] CMD_POLL  = 8'h01;

  logic [1:0]    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          start_q, start_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [PW-1:0] icnt_q, icnt_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [31:0]   btn_q, btn_d;
  logic [15:0]   id_q, id_d;
  logic          pres_q, pres_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
`ifdef JB_SCHED_RETRY_EN
  logic          retry_q, retry_d;
`endif

  logic       is_poll;
  logic       expired;
  logic       good;
  logic       launch;
  logic       fail;
  logic [7:0] launch_cmd;

  assign is_poll    = (cmd_q == CMD_POLL);
  assign expired    = (tcnt_q == T_LAST);
  assign good       = (phy_rx_bytes == (is_poll ? 3'd4 : 3'd3));
  assign launch_cmd = pres_q ? CMD_POLL : CMD_PROBE;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    start_d = 1'b0;
    tcnt_d  = tcnt_q;
    icnt_d  = icnt_q;
    miss_d  = miss_q;
    btn_d   = btn_q;
    id_d    = id_q;
    pres_d  = pres_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    launch  = 1'b0;
    fail    = 1'b0;
`ifdef JB_SCHED_RETRY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (enable) launch = 1'b1;
      end
      S_TX: begin
        if (phy_tx_done) begin
          state_d = S_RX;
          tcnt_d  = '0;
        end
      end
      S_RX: begin
        // rx_done takes priority over an expiring timeout
        if (phy_rx_done || expired) begin
          icnt_d  = '0;
          state_d = enable ? S_WAIT : S_IDLE;
          if (phy_rx_done && good) begin
            miss_d = '0;
            if (is_poll) begin
              btn_d   = phy_rx_data;
              valid_d = 1'b1;
            end else begin
              id_d   = phy_rx_data[31:16];
              pres_d = 1'b1;
            end
          end else begin
`ifdef JB_SCHED_RETRY_EN
            if (is_poll && !retry_q) begin
              state_d = S_TX;
              start_d = 1'b1;
              retry_d = 1'b1;
            end else begin
              fail = 1'b1;
            end
`else
            fail = 1'b1;
`endif
          end
        end else if (tcnt_q != T_MAX) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (icnt_q == P_LAST) begin
          launch = 1'b1;
        end else if (icnt_q != P_MAX) begin
          icnt_d = icnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d = S_TX;
      start_d = 1'b1;
      cmd_d   = launch_cmd;
`ifdef JB_SCHED_RETRY_EN
      retry_d = 1'b0;
`endif
    end

    // Only polls count toward losing the controller
    if (fail) begin
      err_d = 1'b1;
      if (is_poll) begin
        if (miss_q >= M_LAST) begin
          miss_d = '0;
          pres_d = 1'b0;
        end else begin
          miss_d = miss_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      start_q <= 1'b0;
      tcnt_q  <= '0;
      icnt_q  <= '0;
      miss_q  <= '0;
      btn_q   <= '0;
      id_q    <= '0;
      pres_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef JB_SCHED_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      start_q <= start_d;
      tcnt_q  <= tcnt_d;
      icnt_q  <= icnt_d;
      miss_q  <= miss_d;
      btn_q   <= btn_d;
      id_q    <= id_d;
      pres_q  <= pres_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef JB_SCHED_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign phy_tx_start  = start_q;
  assign phy_tx_cmd    = cmd_q;
  assign phy_rx_en     = (state_q == S_RX);
  assign btn_state     = btn_q;
  assign state_valid   = valid_q;
  assign cntlr_id      = id_q;
  assign cntlr_present = pres_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_joybus_poll_sched.sv
// Bench for joybus_poll_sched: directed and random transactions
// against a transaction-level model of the scheduler.

module tb_joybus_poll_sched;

  localparam int POLL = 30;
  localparam int TO   = 12;
  localparam int MAXM = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        phy_tx_start;
  logic [7:0]  phy_tx_cmd;
  logic        phy_tx_done = 1'b0;
  logic        phy_rx_en;
  logic        phy_rx_done = 1'b0;
  logic [31:0] phy_rx_data = '0;
  logic [2:0]  phy_rx_bytes = '0;
  logic [31:0] btn_state;
  logic        state_valid;
  logic [15:0] cntlr_id;
  logic        cntlr_present;
  logic        err_timeout;

  joybus_poll_sched #(
    .POLL_CYCLES(POLL),
    .TIMEOUT_CYCLES(TO),
    .MAX_MISSES(MAXM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .phy_tx_start(phy_tx_start),
    .phy_tx_cmd(phy_tx_cmd),
    .phy_tx_done(phy_tx_done),
    .phy_rx_en(phy_rx_en),
    .phy_rx_done(phy_rx_done),
    .phy_rx_data(phy_rx_data),
    .phy_rx_bytes(phy_rx_bytes),
    .btn_state(btn_state),
    .state_valid(state_valid),
    .cntlr_id(cntlr_id),
    .cntlr_present(cntlr_present),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int seen_err = 0;
  int seen_valid = 0;

  // Transaction-level model of controller-facing state
  bit          m_present;
  int          m_miss;
  logic [31:0] m_btn;
  logic [15:0] m_id;
  bit          m_retried;
  int          m_err;
  int          m_valid;

  always @(posedge clk) begin
    if (err_timeout) seen_err <= seen_err + 1;
    if (state_valid) seen_valid <= seen_valid + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_present = 0;
    m_miss    = 0;
    m_btn     = '0;
    m_id      = '0;
    m_retried = 0;
  endtask

  // Expect the next phy_tx_start exactly n cycles from now
  task automatic expect_start(input int n, input bit strays);
    int early;
    early = 0;
    for (int i = 0; i < n; i++) begin
      if (phy_tx_start) early++;
      if (strays) begin
        phy_tx_done  = ($urandom_range(0, 5) == 0);
        phy_rx_done  = ($urandom_range(0, 5) == 0);
        phy_rx_bytes = 3'd4;
        phy_rx_data  = $urandom;
      end
      tick();
      phy_tx_done = 1'b0;
      phy_rx_done = 1'b0;
    end
    chk("early_start", early, 0);
    chk("tx_start", phy_tx_start, 1);
  endtask

  // kind: 0 answered, 1 answered with given byte count, 2 no answer
  // r: RX cycles before the response cycle
  task automatic txn(input int kind, input int r_in,
                     input logic [2:0] bytes_in,
                     input logic [31:0] data, input bit drop_en);
    bit         is_poll;
    bit         good;
    bit         retry;
    bit         exp_valid;
    bit         exp_err;
    int         r;
    int         d;
    int         bad;
    logic [7:0] exp_cmd;
    logic [2:0] bytes;
    is_poll = m_present;
    exp_cmd = is_poll ? 8'h01 : 8'h00;
    r = (kind == 2) ? TO - 1 : r_in;
    d = $urandom_range(0, 3);
    bad = 0;
    chk("cmd", phy_tx_cmd, exp_cmd);
    for (int i = 0; i < d; i++) begin
      phy_rx_done  = $urandom_range(0, 1);
      phy_rx_bytes = is_poll ? 3'd4 : 3'd3;
      phy_rx_data  = $urandom;
      tick();
      phy_rx_done = 1'b0;
      if (phy_tx_start || phy_rx_en) bad++;
      if (phy_tx_cmd !== exp_cmd) bad++;
    end
    phy_tx_done = 1'b1;
    tick();
    phy_tx_done = 1'b0;
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < r; i++) begin
      if (!phy_rx_en || err_timeout || state_valid) bad++;
      if (phy_tx_start) bad++;
      phy_tx_done = ($urandom_range(0, 3) == 0);
      tick();
      phy_tx_done = 1'b0;
    end
    if (!phy_rx_en) bad++;
    bytes = (kind == 0) ? (is_poll ? 3'd4 : 3'd3) : bytes_in;
    if (kind != 2) begin
      phy_rx_done  = 1'b1;
      phy_rx_data  = data;
      phy_rx_bytes = bytes;
    end
    tick();
    phy_rx_done = 1'b0;
    chk("rx_window", bad, 0);

    good = (kind != 2) && (bytes == (is_poll ? 3'd4 : 3'd3));
    retry = 0;
    exp_valid = 0;
    exp_err = 0;
    if (good) begin
      if (is_poll) begin
        m_btn = data;
        exp_valid = 1;
      end else begin
        m_id = data[31:16];
        m_present = 1;
      end
      m_miss = 0;
    end else begin
`ifdef JB_SCHED_RETRY_EN
      retry = is_poll && !m_retried;
`endif
      if (!retry) begin
        exp_err = 1;
        if (is_poll) begin
          m_miss++;
          if (m_miss == MAXM) begin
            m_present = 0;
            m_miss = 0;
          end
        end
      end
    end
    m_retried = retry;
    m_err += int'(exp_err);
    m_valid += int'(exp_valid);
    chk("state_valid", state_valid, exp_valid);
    chk("err_timeout", err_timeout, exp_err);
    chk("btn_state", btn_state, m_btn);
    chk("cntlr_id", cntlr_id, m_id);
    chk("present", cntlr_present, m_present);
  endtask

  task automatic next_start();
    expect_start(m_retried ? 0 : POLL, 1);
  endtask

  initial begin
    int k;
    int held;
    model_reset();
    m_err = 0;
    m_valid = 0;
    repeat (3) tick();
    chk("rst_tx_start", phy_tx_start, 0);
    chk("rst_rx_en", phy_rx_en, 0);
    chk("rst_cmd", phy_tx_cmd, 0);
    chk("rst_btn", btn_state, 0);
    chk("rst_valid", state_valid, 0);
    chk("rst_id", cntlr_id, 0);
    chk("rst_present", cntlr_present, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    expect_start(1, 0);

    // probe answered
    txn(0, 4, 3'd0, 32'h0500_0200, 0);
    chk("probe_id", cntlr_id, 16'h0500);
    chk("probe_present", cntlr_present, 1);
    next_start();

    // poll with A,B,Z pressed
    txn(0, 2, 3'd0, 32'hE000_0000, 0);
    chk("btn_abz", btn_state[31:29], 3'b111);
    next_start();

    // short poll response, then a good poll clears the miss
    txn(1, 3, 3'd2, 32'h1234_5678, 0);
    next_start();
    if (m_retried) begin
      txn(1, 3, 3'd2, 32'h1234_5678, 0);
      next_start();
    end
    chk("short_btn_held", btn_state, 32'hE000_0000);
    txn(0, 1, 3'd0, 32'h8000_0000, 0);
    next_start();

    // silent controller: presence drops after MAXM counted misses
    for (int i = 0; i < MAXM; i++) begin
      txn(2, 0, 3'd0, 32'h0, 0);
      next_start();
      if (m_retried) begin
        txn(2, 0, 3'd0, 32'h0, 0);
        next_start();
      end
    end
    chk("lost_present", cntlr_present, 0);
    chk("lost_probe_cmd", phy_tx_cmd, 8'h00);

    txn(0, 5, 3'd0, 32'h0500_0200, 0);
    next_start();

    // response on the exact expiry cycle
    txn(0, TO - 1, 3'd0, 32'h4000_0000, 0);
    next_start();

`ifdef JB_SCHED_RETRY_EN
    txn(2, 0, 3'd0, 32'h0, 0);
    chk("retry_pending", m_retried, 1);
    next_start();
    txn(0, 2, 3'd0, 32'h2000_0000, 0);
    next_start();
`endif

    // random traffic
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 3);
      txn((k < 2) ? 0 : k - 1, $urandom_range(0, TO - 1),
          3'($urandom_range(0, 7)), $urandom, 0);
      next_start();
    end
    if (!m_present) begin
      txn(0, 1, 3'd0, 32'h0500_0200, 0);
      next_start();
    end

    // disable mid-RX: response latched, then idle
    txn(0, 3, 3'd0, 32'h2000_0001, 1);
    held = 0;
    for (int i = 0; i < 3 * POLL; i++) begin
      if (phy_tx_start || phy_rx_en) held++;
      phy_tx_done = ($urandom_range(0, 4) == 0);
      phy_rx_done = ($urandom_range(0, 4) == 0);
      phy_rx_bytes = 3'd4;
      tick();
      phy_tx_done = 1'b0;
      phy_rx_done = 1'b0;
    end
    chk("idle_no_start", held, 0);
    chk("idle_btn", btn_state, 32'h2000_0001);
    chk("idle_present", cntlr_present, 1);
    enable = 1'b1;
    expect_start(1, 0);

    // reset during RX
    phy_tx_done = 1'b1;
    tick();
    phy_tx_done = 1'b0;
    chk("rx_en_before_rst", phy_rx_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rx_en_drop", phy_rx_en, 0);
    chk("rst_present_drop", cntlr_present, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    expect_start(1, 0);
    chk("rst_probe_cmd", phy_tx_cmd, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_start_drop", phy_tx_start, 0);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    chk("total_err", seen_err, m_err);
    chk("total_valid", seen_valid, m_valid);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
